// File: rtl/ps2_scan_sequencer_if.sv
// Bundle between the PS/2 receiver, the scan sequencer and the key-event consumer.
// The slave modport is the sequencer's view; the master modport drives it.
interface ps2_scan_sequencer_if;
    logic       rx_done_tick;
    logic [7:0] rx_dout;
    logic       rx_err;
    logic       rx_en;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       seq_err;
    logic       ovf;
    logic       clr_ovf;
    logic [7:0] err_cnt;

    modport master (
        output rx_done_tick, rx_dout, rx_err, ev_ready, clr_ovf,
        input  rx_en, ev_valid, ev_code, ev_ext, ev_break, seq_err, ovf, err_cnt
    );

    modport slave (
        input  rx_done_tick, rx_dout, rx_err, ev_ready, clr_ovf,
        output rx_en, ev_valid, ev_code, ev_ext, ev_break, seq_err, ovf, err_cnt
    );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// Folds the PS/2 byte stream (E0/F0 prefixes) into make/break key events and
// queues them in a show-ahead FIFO with backpressure, timeout and error reporting.
module ps2_scan_sequencer #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_scan_sequencer_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]    CODE_EXT = 8'hE0;
    localparam logic [7:0]    CODE_BRK = 8'hF0;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tmo;
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_valid;
    logic [9:0]      r_head;
    logic            r_seq_err;
    logic            r_ovf;
    logic [7:0]      r_err_cnt;

    state_t          w_next_state;
    logic            w_emit;
    logic            w_ev_ext;
    logic            w_ev_brk;
    logic            w_abort;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [CW-1:0]   w_count_next;
    logic [AW-1:0]   w_rptr_inc;
    logic            w_head_load;
    logic [9:0]      w_head_next;
    logic [9:0]      w_push_data;

    // Prefix decoding: next state, event emission and abort causes.
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_ev_ext     = 1'b0;
        w_ev_brk     = 1'b0;
        w_abort      = 1'b0;
        if (bus.rx_done_tick) begin
            if (bus.rx_err) begin
                w_next_state = ST_IDLE;
                w_abort      = 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.rx_dout == CODE_EXT) begin
                            w_next_state = ST_EXT;
                        end else if (bus.rx_dout == CODE_BRK) begin
                            w_next_state = ST_BRK;
                        end else begin
                            w_emit = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (bus.rx_dout == CODE_BRK) begin
                            w_next_state = ST_EXTBRK;
                        end else if (bus.rx_dout == CODE_EXT) begin
                            w_abort = 1'b1;
                        end else begin
                            w_emit       = 1'b1;
                            w_ev_ext     = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXTBRK: begin
                        w_next_state = ST_IDLE;
                        if ((bus.rx_dout == CODE_EXT) || (bus.rx_dout == CODE_BRK)) begin
                            w_abort = 1'b1;
                        end else begin
                            w_emit   = 1'b1;
                            w_ev_ext = (r_state == ST_EXTBRK);
                            w_ev_brk = 1'b1;
                        end
                    end
                    default: begin
                        w_next_state = ST_IDLE;
                    end
                endcase
            end
        end else if ((r_state != ST_IDLE) && (r_tmo == TMO_LAST)) begin
            w_next_state = ST_IDLE;
            w_abort      = 1'b1;
        end else begin
            w_next_state = r_state;
        end
    end

    assign w_pop       = r_valid & bus.ev_ready;
    assign w_full      = (r_count == FULL_CNT);
    assign w_push      = w_emit & (~w_full | w_pop);
    assign w_drop      = w_emit & w_full & ~w_pop;
    assign w_rptr_inc  = r_rptr + {{(AW-1){1'b0}}, 1'b1};
    assign w_push_data = {w_ev_ext, w_ev_brk, bus.rx_dout};

    // FIFO occupancy and the next show-ahead head (holds when the FIFO drains).
    always_comb begin
        w_count_next = r_count;
        w_head_load  = 1'b0;
        w_head_next  = r_head;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   w_count_next = r_count - {{(CW-1){1'b0}}, 1'b1};
            default: w_count_next = r_count;
        endcase
        if (w_pop && (r_count > {{(CW-2){1'b0}}, 2'b01})) begin
            w_head_load = 1'b1;
            w_head_next = r_mem[w_rptr_inc];
        end else if (w_push && ((r_count == {CW{1'b0}}) ||
                                (w_pop && (r_count == {{(CW-1){1'b0}}, 1'b1})))) begin
            w_head_load = 1'b1;
            w_head_next = w_push_data;
        end else begin
            w_head_load = 1'b0;
            w_head_next = r_head;
        end
    end

    // Sequencer state, timeout counter and error/overflow status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_tmo     <= {TW{1'b0}};
            r_seq_err <= 1'b0;
            r_ovf     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_seq_err <= w_abort;
            if (bus.rx_done_tick || (r_state == ST_IDLE) || w_abort) begin
                r_tmo <= {TW{1'b0}};
            end else begin
                r_tmo <= r_tmo + {{(TW-1){1'b0}}, 1'b1};
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
            if (w_abort && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end
    end

    // Event FIFO storage, pointers and registered head fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 10'd0;
            end
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            r_valid <= 1'b0;
            r_head  <= 10'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_push_data;
                r_wptr        <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= w_rptr_inc;
            end
            if (w_head_load) begin
                r_head <= w_head_next;
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != {CW{1'b0}});
        end
    end

    assign bus.rx_en    = (r_count < FULL_CNT);
    assign bus.ev_valid = r_valid;
    assign bus.ev_ext   = r_head[9];
    assign bus.ev_break = r_head[8];
    assign bus.ev_code  = r_head[7:0];
    assign bus.seq_err  = r_seq_err;
    assign bus.ovf      = r_ovf;
    assign bus.err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Cycle-by-cycle check of ps2_scan_sequencer against a queue-based event model,
// driven by the directed scenarios followed by random byte traffic.
module tb_ps2_scan_sequencer;
    localparam int TMO   = 40;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_scan_sequencer_if bus();

    ps2_scan_sequencer #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: pending prefixes, event queue {ext,brk,code}, sticky flags.
    logic [9:0] m_q[$];
    logic [9:0] m_head;
    bit         m_ext, m_brk, m_ovf, m_seq_err;
    int         m_age, m_err_cnt;
    bit         cur_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_head = 10'd0; m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
        m_seq_err = 1'b0; m_age = 0; m_err_cnt = 0;
    endtask

    task automatic model_edge(input bit tick, input logic [7:0] b, input bit err,
                              input bit ready, input bit clr);
        bit abort = 1'b0;
        bit emit  = 1'b0;
        bit drop  = 1'b0;
        logic [9:0] ev = 10'd0;
        bit pop = (m_q.size() > 0) && ready;
        if (tick) begin
            m_age = 0;
            if (err) begin
                abort = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
            end else if (b == 8'hE0) begin
                if (!m_ext && !m_brk) m_ext = 1'b1;
                else if (m_ext && !m_brk) abort = 1'b1;
                else begin abort = 1'b1; m_ext = 1'b0; m_brk = 1'b0; end
            end else if (b == 8'hF0) begin
                if (!m_brk) m_brk = 1'b1;
                else begin abort = 1'b1; m_ext = 1'b0; m_brk = 1'b0; end
            end else begin
                emit = 1'b1; ev = {m_ext, m_brk, b};
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end else if (m_ext || m_brk) begin
            m_age++;
            if (m_age == TMO) begin
                abort = 1'b1; m_ext = 1'b0; m_brk = 1'b0; m_age = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (emit) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (abort && m_err_cnt < 255) m_err_cnt++;
        m_seq_err = abort;
        if (m_q.size() > 0) m_head = m_q[0];
    endtask

    task automatic check_outputs();
        check_eq("ev_valid", bus.ev_valid, (m_q.size() > 0));
        check_eq("ev_code",  bus.ev_code,  m_head[7:0]);
        check_eq("ev_ext",   bus.ev_ext,   m_head[9]);
        check_eq("ev_break", bus.ev_break, m_head[8]);
        check_eq("rx_en",    bus.rx_en,    (m_q.size() < DEPTH));
        check_eq("seq_err",  bus.seq_err,  m_seq_err);
        check_eq("ovf",      bus.ovf,      m_ovf);
        check_eq("err_cnt",  bus.err_cnt,  m_err_cnt);
    endtask

    task automatic step(input bit tick, input logic [7:0] b, input bit err,
                        input bit ready, input bit clr);
        @(negedge clk);
        bus.rx_done_tick = tick;
        bus.rx_dout      = b;
        bus.rx_err       = err;
        bus.ev_ready     = ready;
        bus.clr_ovf      = clr;
        @(posedge clk);
        model_edge(tick, b, err, ready, clr);
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [7:0] b, input bit err);
        step(1'b1, b, err, cur_ready, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, cur_ready, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.rx_done_tick = 1'b0; bus.rx_dout = 8'h00; bus.rx_err = 1'b0;
        bus.ev_ready = 1'b0; bus.clr_ovf = 1'b0;
        #1;
        check_eq("rst_ev_valid", bus.ev_valid, 1'b0);
        check_eq("rst_ev_code",  bus.ev_code,  8'h00);
        check_eq("rst_ev_ext",   bus.ev_ext,   1'b0);
        check_eq("rst_ev_break", bus.ev_break, 1'b0);
        check_eq("rst_seq_err",  bus.seq_err,  1'b0);
        check_eq("rst_ovf",      bus.ovf,      1'b0);
        check_eq("rst_err_cnt",  bus.err_cnt,  8'h00);
        check_eq("rst_rx_en",    bus.rx_en,    1'b1);
        repeat (3) @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        int k;
        model_reset();
        cur_ready = 1'b1;
        do_reset();

        // Basic make, break, extended and extended-break sequences.
        send(8'h1C, 1'b0); idle(2);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0); idle(2);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0); idle(2);
        send(8'hE0, 1'b0); send(8'h75, 1'b0); idle(2);
        send(8'hE1, 1'b0); idle(2);

        // Fill the FIFO with the consumer stalled, then drain it.
        cur_ready = 1'b0;
        send(8'h15, 1'b0); idle(1); send(8'h1D, 1'b0); idle(1);
        send(8'h24, 1'b0); idle(1); send(8'h2D, 1'b0); idle(1);
        check_eq("rx_en_full", bus.rx_en, 1'b0);
        send(8'h35, 1'b0); idle(1);
        check_eq("ovf_set", bus.ovf, 1'b1);
        check_eq("head_oldest", bus.ev_code, 8'h15);
        cur_ready = 1'b1;
        idle(6);
        check_eq("rx_en_drained", bus.rx_en, 1'b1);
        check_eq("last_popped", bus.ev_code, 8'h2D);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check_eq("ovf_clr", bus.ovf, 1'b0);

        // Timeout after a lone prefix, then recovery.
        send(8'hE0, 1'b0); idle(TMO + 3);
        check_eq("tmo_err_cnt", bus.err_cnt, 8'd1);
        send(8'h1C, 1'b0); idle(2);

        // Receiver error and illegal prefix.
        send(8'hF0, 1'b0); send(8'h33, 1'b1); idle(2);
        send(8'hF0, 1'b0); send(8'hE0, 1'b0); idle(2);
        check_eq("illegal_err_cnt", bus.err_cnt, 8'd3);

        // Reset in the middle of a sequence.
        send(8'hE0, 1'b0); send(8'hF0, 1'b0);
        do_reset();
        send(8'h74, 1'b0); idle(2);
        check_eq("post_rst_code", bus.ev_code, 8'h74);
        check_eq("post_rst_ext",  bus.ev_ext,  1'b0);

        // Random traffic with prefixes, errors, stalls and timeouts.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) cur_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) idle(TMO + 5);
            k = $urandom_range(0, 9);
            if (k < 2) b = 8'hE0;
            else if (k < 4) b = 8'hF0;
            else b = 8'($urandom);
            step(($urandom_range(0, 99) < 25), b, ($urandom_range(0, 29) == 0),
                 cur_ready, ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
